fifo_sync_param: RTL



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_sync_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised synchronous FIFO.
// Default parameter set matches the DDR3 command/write-data queues.
package fifo_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  localparam int DDR3_WIDTH     = 8;
  localparam int DDR3_DEPTH     = 32;
  localparam int DDR3_AF_THRESH = 28;
  localparam int DDR3_AE_THRESH = 4;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with thresholds, overflow/underflow pulses
// and optional first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DDR3_WIDTH,
  parameter int DEPTH     = DDR3_DEPTH,
  parameter int AF_THRESH = DDR3_AF_THRESH,
  parameter int AE_THRESH = DDR3_AE_THRESH,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   put,
  input  logic                   get,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] fillcount,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int       ADDR_W  = addr_w(DEPTH);
  localparam int       CNT_W   = cnt_w(DEPTH);
  localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of 2 and at least 4");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [WIDTH-1:0]  ram_rdata;
  logic              get_ok, put_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign fillcount    = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A put into a full FIFO is only legal when the same edge frees a slot.
  assign get_ok = get & ~empty;
  assign put_ok = put & (~full | get_ok);

  fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (put_ok & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = put & ~put_ok;
    udf_d    = get & ~get_ok;

    if (put_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (get_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (RD_MODE == RD_STD) begin
        dout_d = ram_rdata;
      end
    end

    unique case ({put_ok, get_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // In FWFT mode the head entry is presented straight from storage.
  assign data_out = (RD_MODE == RD_FWFT) ? ram_rdata : dout_q;

endmodule
